// File: rtl/pe_mac_cfg.sv
// pe_mac_cfg: configurable systolic-array processing element.
// OS mode accumulates x*y locally; WS mode adds x*w into a top-to-bottom partial-sum chain.
// Results leave through a serial drain chain (res_i -> res_o), one PE per cycle.
module pe_mac_cfg #(
    parameter int DW    = 8,
    parameter int ACC_W = 24,
    parameter bit SAT   = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             mode,
    input  logic [DW-1:0]    x_i,
    output logic [DW-1:0]    x_o,
    input  logic             x_vld_i,
    output logic             x_vld_o,
    input  logic [DW-1:0]    y_i,
    output logic [DW-1:0]    y_o,
    input  logic             y_vld_i,
    output logic             y_vld_o,
    input  logic             w_ld,
    input  logic [ACC_W-1:0] psum_i,
    output logic [ACC_W-1:0] psum_o,
    input  logic             dump,
    input  logic [ACC_W-1:0] res_i,
    output logic [ACC_W-1:0] res_o,
    input  logic             res_vld_i,
    output logic             res_vld_o,
    output logic             ovf_o
);

    localparam logic [ACC_W-1:0] AccMax = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] AccMin = {1'b1, {(ACC_W-1){1'b0}}};

    logic [ACC_W-1:0]        acc_q, acc_d;
    logic [DW-1:0]           w_q, w_d;
    logic                    mode_q;
    logic                    mode_chg;

    logic [DW-1:0]           mul_b;
    logic signed [2*DW-1:0]  prod;
    logic [ACC_W:0]          prod_ext;
    logic [ACC_W-1:0]        addend;
    logic [ACC_W:0]          sum;
    logic                    add_ovf;
    logic [ACC_W-1:0]        add_res;
    logic [ACC_W-1:0]        acc_nxt;

    logic [ACC_W-1:0]        psum_d;
    logic [ACC_W-1:0]        res_d;
    logic                    res_vld_d;
    logic                    ovf_d;

    assign mode_chg = (mode != mode_q);

    // Shared multiply-add: one adder serves acc (OS) or the psum chain (WS).
    always_comb begin
        mul_b    = mode ? w_q : y_i;
        prod     = $signed(x_i) * $signed(mul_b);
        prod_ext = {{(ACC_W + 1 - 2 * DW){prod[2*DW-1]}}, prod};
        addend   = mode ? psum_i : acc_q;
        sum      = {addend[ACC_W-1], addend} + prod_ext;
        // Top two sum bits disagree exactly when the result left the ACC_W range.
        add_ovf  = sum[ACC_W] ^ sum[ACC_W-1];
        if (add_ovf && SAT) begin
            add_res = sum[ACC_W] ? AccMin : AccMax;
        end else begin
            add_res = sum[ACC_W-1:0];
        end
    end

    // Next-state selection: mode change > dump > MAC (clr/rst handled in the register).
    always_comb begin
        acc_d     = acc_q;
        w_d       = w_q;
        acc_nxt   = acc_q;
        psum_d    = '0;
        res_d     = res_i;
        res_vld_d = res_vld_i;
        ovf_d     = ovf_o;

        if (mode_chg) begin
            // Stale acc/weight from the other mode must not leak into the new one.
            acc_d = '0;
            w_d   = '0;
            if (mode) begin
                psum_d = psum_i;
            end
        end else if (mode) begin
            if (w_ld) begin
                w_d = y_i;
            end
            if (x_vld_i) begin
                psum_d = add_res;
                ovf_d  = ovf_o | add_ovf;
            end else begin
                psum_d = psum_i;
            end
        end else begin
            if (x_vld_i && y_vld_i) begin
                acc_nxt = add_res;
                ovf_d   = ovf_o | add_ovf;
            end
            if (dump) begin
                // Local result overrides whatever arrives from upstream this cycle.
                res_d     = acc_nxt;
                res_vld_d = 1'b1;
                acc_d     = '0;
            end else begin
                acc_d = acc_nxt;
            end
        end
    end

    // State and output registers: async reset, then synchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q     <= '0;
            w_q       <= '0;
            mode_q    <= 1'b0;
            x_o       <= '0;
            x_vld_o   <= 1'b0;
            y_o       <= '0;
            y_vld_o   <= 1'b0;
            psum_o    <= '0;
            res_o     <= '0;
            res_vld_o <= 1'b0;
            ovf_o     <= 1'b0;
        end else if (clr) begin
            acc_q     <= '0;
            w_q       <= '0;
            mode_q    <= mode;
            x_o       <= '0;
            x_vld_o   <= 1'b0;
            y_o       <= '0;
            y_vld_o   <= 1'b0;
            psum_o    <= '0;
            res_o     <= '0;
            res_vld_o <= 1'b0;
            ovf_o     <= 1'b0;
        end else begin
            acc_q     <= acc_d;
            w_q       <= w_d;
            mode_q    <= mode;
            x_o       <= x_i;
            x_vld_o   <= x_vld_i;
            y_o       <= y_i;
            y_vld_o   <= y_vld_i;
            psum_o    <= psum_d;
            res_o     <= res_d;
            res_vld_o <= res_vld_d;
            ovf_o     <= ovf_d;
        end
    end

endmodule

// File: doc/pe_mac_cfg.md
# pe_mac_cfg

Parametrised second-generation processing element for the systolic matrix multiplier. It supports two modes. In output-stationary (OS) mode it accumulates x·y locally with validity tracking. In weight-stationary (WS) mode it holds a preloaded weight and adds x·w to a partial sum passing from top to bottom. Additional features over the first-generation PE:
- configurable accumulator width;
- optional saturation with a sticky overflow flag;
- a result drain shift chain, so array results leave serially without a wide output bus.

## Interface
- DW, 8, signed operand width (x, y, weight)
- ACC_W, 24, signed accumulator / partial-sum width; must be ≥ 2*DW
- SAT, 1, 1 = saturate accumulations to ACC_W range; 0 = two's-complement wrap
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset; one clock, no other clock domains
- clr  in  1  synchronous clear of accumulator, result register, ovf, valids
- mode  in  1  0 = OS, 1 = WS; quasi-static
- x_i, x_o  in/out  DW  signed row operand; x_o is x_i delayed 1 cycle
- x_vld_i, x_vld_o  in/out  1  x valid, forwarded with x
- y_i, y_o  in/out  DW  signed column operand / weight-load chain; y_o is y_i delayed 1 cycle
- y_vld_i, y_vld_o  in/out  1  y valid, forwarded with y
- w_ld  in  1  WS: capture y_i into weight register
- psum_i, psum_o  in/out  ACC_W  WS partial-sum chain (top in, bottom out)
- dump  in  1  OS: transfer accumulator to result register, clear accumulator
- res_i, res_o  in/out  ACC_W  result drain chain
- res_vld_i, res_vld_o  in/out  1  result valid along drain chain
- ovf_o  out  1  sticky saturation/overflow flag

## Operation
- **Arithmetic**
  - prod = x_i*y_i (OS) or x_i*w_reg (WS), signed, 2*DW bits, sign-extended to ACC_W.
  - Sum is formed in ACC_W+1 bits.
  - Out of range with SAT=1: clamp to +(2^(ACC_W-1))-1 or −2^(ACC_W-1), set ovf_o.
  - Out of range with SAT=0: keep the low ACC_W bits (wrap) and still set ovf_o.
- **Forwarding** (both modes, every non-reset, non-clr cycle): x_o/x_vld_o ← x_i/x_vld_i; y_o/y_vld_o ← y_i/y_vld_i.
- **OS mode**
  - Accumulate acc ← sat(acc+prod) only when x_vld_i && y_vld_i; otherwise acc holds.
  - psum_o ← 0.
- **WS mode**
  - w_ld=1: w_reg ← y_i.
  - psum_o ← x_vld_i ? sat(psum_i+prod) : psum_i. A weight loaded in cycle n is used from cycle n+1.
  - acc holds; dump is ignored.
- **Drain chain**
  - dump=1 (OS): res_o ← acc_next, where acc_next includes this cycle's product if valid. res_vld_o ← 1; acc ← 0.
  - Otherwise: res_o ← res_i; res_vld_o ← res_vld_i.
  - An N-PE chain therefore shifts out N results on N consecutive cycles after one broadcast dump.
- **Mode change**
  - A registered copy of mode is kept; when mode differs from it, acc and w_reg are cleared that cycle.
  - The shift/forward registers are unaffected.
- **Priority**: rst > clr > mode change > dump > MAC.
  - clr zeroes acc, w_reg, res_o, res_vld_o, psum_o, ovf_o, x_o, y_o and the valids.
- **ovf_o** stays set until rst or clr.

## Timing
- Every output is registered; latency is 1 cycle from input to output for x, y, psum, res and valids.
- Reset value of every output is 0, as are acc, w_reg and the registered mode. Reset applies immediately on rst rising, independent of clk.
- Reset mid-accumulation or mid-drain: all in-flight data is lost; the first valid MAC after rst falls starts from acc=0.
- dump with res_vld_i=1 in the same cycle: the local result wins and the upstream result is dropped. The controller must space dumps ≥ N cycles apart for an N-deep chain.
- No backpressure: the drain consumer must accept one result per cycle while res_vld_o=1.

## Test plan
- **Reset:** drive inputs non-zero, pulse rst asynchronously between edges → all outputs 0 immediately and after release; first MAC x=2,y=3 then dump → res_o=6.
- **OS accumulate/dump:** x=3,y=−4 both valid 3 cycles with one invalid gap → acc = −36; dump on the 3rd valid cycle → next cycle res_o=−36, res_vld_o=1, then acc=0.
- **Saturation:** ACC_W=16, x=y=−128 valid 2 cycles (16384+16384).
  - SAT=1 → res 32767, ovf_o=1.
  - SAT=0 → res −32768, ovf_o=1.
  - ovf_o cleared only by clr.
- **WS:** y_i=5 with w_ld; next cycle x_i=−7 valid, psum_i=100 → psum_o=65. Then x_vld_i=0, psum_i=9 → psum_o=9.
- **Drain chain:** 3-PE chain holding results 1, 2, 3; one dump → tail res_o emits 3, 2, 1 on consecutive cycles with res_vld_o high 3 cycles, then 0.
- **Simultaneous events:**
  - clr+dump same cycle → res_vld_o=0, acc=0.
  - mode toggled OS→WS with acc=50 → acc and w_reg cleared; psum chain passes psum_i unchanged until w_ld.
